ca_tx_delay_ctrl: RTL and testbench
===================================

Name: ca_tx_delay_ctrl

Overview:
- Fabric-side sequencer that drives the dynamic TX delay-line controls of one DDR4 command/address output lane (e.g. ACT_N).
- Accepts load/increment/decrement requests from the training logic.
- Emits correctly spaced DELAY_LINE_LOAD/MOVE/DIRECTION pulses, tracks the tap position, and flags out-of-range conditions.
- Sits directly upstream of the lane's IOD delay-line port, in the FAB_CLK domain.

Parameters:
- TAP_W, 8, width of tap position and step count.
- TAP_INIT, 1, tap value the IOD adopts on DELAY_LINE_LOAD (matches its static TX delay setting).
- TAP_MAX, 255, highest legal tap position.
- SETTLE_CYCLES, 4, FAB_CLK cycles to wait after each MOVE before sampling out-of-range; legal range 1..15.

Ports:
- FAB_CLK  in  1  fabric clock.
- ARST_N  in  1  reset, asynchronous, active-low.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  request ready; high only in IDLE.
- REQ_OP  in  2  operation: 00 LOAD, 01 INC, 10 DEC, 11 NOP.
- REQ_COUNT  in  TAP_W  step count for INC/DEC.
- DONE  out  1  one-cycle pulse when a request completes, with or without error.
- ERR  out  1  sticky error flag.
- ERR_CLR  in  1  clears ERR.
- BUSY  out  1  high whenever the state is not IDLE.
- TAP_POS  out  TAP_W  current tracked tap position.
- DELAY_LINE_LOAD  out  1  to IOD.
- DELAY_LINE_MOVE  out  1  to IOD.
- DELAY_LINE_DIRECTION  out  1  to IOD; 1 = increase delay.
- DELAY_LINE_OUT_OF_RANGE  in  1  from IOD; registered once before use.

Behaviour:
- Reset values: REQ_READY=0 during reset and 1 after it; DONE=0, ERR=0, BUSY=0, TAP_POS=TAP_INIT; LOAD, MOVE and DIRECTION all 0. Reset mid-operation aborts immediately with no DONE pulse.
- Handshake: a request is accepted on a rising edge with REQ_VALID & REQ_READY. REQ_OP and REQ_COUNT are captured at acceptance.
- FSM states: IDLE, LOAD, SETUP, MOVE, SETTLE, FIN.
  - IDLE: on accept, LOAD op -> LOAD; INC/DEC with count>0 -> SETUP; NOP or count=0 -> FIN.
  - LOAD: DELAY_LINE_LOAD high for exactly 1 cycle, TAP_POS <= TAP_INIT, -> FIN.
  - SETUP: DIRECTION driven to the op value. If the step would take the position beyond TAP_MAX (INC) or below 0 (DEC), set ERR and -> FIN without pulsing MOVE. Otherwise -> MOVE.
  - MOVE: DELAY_LINE_MOVE high for exactly 1 cycle, -> SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then sample the registered OUT_OF_RANGE.
    - If asserted: set ERR, leave TAP_POS unchanged, -> FIN.
    - Otherwise: TAP_POS +/-1 and remaining count -1. If remaining is 0 -> FIN; else apply the bounds check again and -> MOVE, skipping SETUP.
  - FIN: DONE high for 1 cycle, -> IDLE.
- DIRECTION is stable from SETUP through the final SETTLE cycle, with one cycle of setup before the first MOVE. It holds its last value in IDLE.
- MOVE and LOAD are never high at the same time.
- Latency for INC/DEC of N steps with no error: DONE is high 2 + N*(1+SETTLE_CYCLES) cycles after the accept edge.
- Latency for LOAD: DONE on the 2nd cycle after accept.
- Latency for NOP or count=0: DONE on the 1st cycle after accept.
- ERR_CLR:
  - Clears ERR on the next edge.
  - If ERR_CLR and a new error occur in the same cycle, the error wins.
- TAP_POS is never outside 0..TAP_MAX.

Optional Feature:
- Macro: CA_TX_DELAY_OOR_BACKOFF_EN.
- Defined: an out-of-range detected in SETTLE triggers one automatic back-off step in the opposite direction. DIRECTION is flipped for 1 cycle, then MOVE for 1 cycle, then SETTLE, then FIN. TAP_POS is left at its pre-failure value and ERR is still set. Error latency grows by 2+SETTLE_CYCLES cycles.
- Undefined: no back-off step; behaviour is as in Behaviour.

Decomposition:
- Shared package (ddr_phy_pkg) holds:
  - REQ_OP encodings (OP_LOAD=2'b00, OP_INC=2'b01, OP_DEC=2'b10, OP_NOP=2'b11);
  - the FSM state enum;
  - the DIR_INC=1 constant.
- No sub-module: the settle counter and bounds check stay inline. A single FSM plus counters is the natural structure.

Test Plan:
- Defaults, SETTLE_CYCLES=4. Reset, then LOAD -> LOAD pulses for 1 cycle at cycle 1, DONE at cycle 2, TAP_POS=1, ERR=0.
- INC count=3 from TAP_POS=1 -> 3 MOVE pulses 5 cycles apart, DIRECTION=1 throughout, DONE at cycle 17, TAP_POS=4.
- DEC count=5 from TAP_POS=2 -> 2 MOVE pulses, then ERR=1 with no 3rd MOVE, DONE pulse, TAP_POS=0.
- INC count=4 with OUT_OF_RANGE forced high after the 2nd MOVE -> ERR=1, TAP_POS=start+1, DONE.
  - With CA_TX_DELAY_OOR_BACKOFF_EN defined: one extra MOVE with DIRECTION=0 before DONE.
- ARST_N pulled low during the 2nd SETTLE -> MOVE/LOAD/DONE=0 immediately, TAP_POS=1. After release, REQ_READY=1 and a NOP yields DONE 1 cycle after accept.
- ERR=1 with ERR_CLR pulsed -> ERR=0 next cycle. ERR_CLR in the same cycle as a bounds error -> ERR stays 1.

Source files
------------

// File: rtl/ddr_phy_pkg.sv
// Shared DDR PHY fabric definitions: request opcodes, sequencer states, delay direction.
package ddr_phy_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    localparam logic DIR_INC = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_MOVE,
        ST_SETTLE,
        ST_FIN
    } ca_state_e;

endpackage

// File: rtl/ca_tx_delay_ctrl.sv
// TX delay-line sequencer for one DDR4 CA lane: paces LOAD/MOVE/DIRECTION, tracks tap, flags range errors.
// Optional CA_TX_DELAY_OOR_BACKOFF_EN: one automatic reverse step after an IOD out-of-range report.
module ca_tx_delay_ctrl
    import ddr_phy_pkg::*;
#(
    parameter int unsigned TAP_W         = 8,
    parameter int unsigned TAP_INIT      = 1,
    parameter int unsigned TAP_MAX       = 255,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [1:0]       REQ_OP,
    input  logic [TAP_W-1:0] REQ_COUNT,
    output logic             DONE,
    output logic             ERR,
    input  logic             ERR_CLR,
    output logic             BUSY,
    output logic [TAP_W-1:0] TAP_POS,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    input  logic             DELAY_LINE_OUT_OF_RANGE
);

    localparam int unsigned SETTLE_W = 4;

    ca_state_e            state_q, state_d;
    logic [TAP_W-1:0]     tap_q, tap_d;
    logic [TAP_W-1:0]     cnt_q, cnt_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    logic                 dir_q, dir_d;
    logic                 err_q, err_d;
    logic                 backoff_q, backoff_d;
    logic                 oor_q;
    logic                 ready_q, busy_q, done_q, load_q, move_q;

    logic [TAP_W-1:0]     tap_step;
    logic                 at_limit, step_at_limit;

    // Position after one step in the current direction, and limit tests before/after that step
    always_comb begin
        tap_step      = (dir_q == DIR_INC) ? tap_q + TAP_W'(1) : tap_q - TAP_W'(1);
        at_limit      = (dir_q == DIR_INC) ? (tap_q == TAP_W'(TAP_MAX)) : (tap_q == '0);
        step_at_limit = (dir_q == DIR_INC) ? (tap_step == TAP_W'(TAP_MAX)) : (tap_step == '0);
    end

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        cnt_d     = cnt_q;
        settle_d  = settle_q;
        dir_d     = dir_q;
        backoff_d = backoff_q;
        err_d     = err_q & ~ERR_CLR;

        unique case (state_q)
            ST_IDLE: begin
                if (REQ_VALID && ready_q) begin
                    cnt_d     = REQ_COUNT;
                    backoff_d = 1'b0;
                    if (REQ_OP == OP_LOAD) begin
                        state_d = ST_LOAD;
                    end else if ((REQ_OP == OP_INC || REQ_OP == OP_DEC) && REQ_COUNT != '0) begin
                        state_d = ST_SETUP;
                        dir_d   = (REQ_OP == OP_INC) ? DIR_INC : ~DIR_INC;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_LOAD: begin
                tap_d   = TAP_W'(TAP_INIT);
                state_d = ST_FIN;
            end
            ST_SETUP: begin
                if (!backoff_q && at_limit) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                settle_d = '0;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q != SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    settle_d = settle_q + SETTLE_W'(1);
                end else if (backoff_q) begin
                    state_d = ST_FIN;
                end else if (oor_q) begin
                    err_d = 1'b1;
`ifdef CA_TX_DELAY_OOR_BACKOFF_EN
                    backoff_d = 1'b1;
                    dir_d     = ~dir_q;
                    state_d   = ST_SETUP;
`else
                    state_d   = ST_FIN;
`endif
                end else begin
                    tap_d = tap_step;
                    cnt_d = cnt_q - TAP_W'(1);
                    if (cnt_q == TAP_W'(1)) begin
                        state_d = ST_FIN;
                    end else if (step_at_limit) begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_MOVE;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so each pulse lines up with its state
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q   <= ST_IDLE;
            tap_q     <= TAP_W'(TAP_INIT);
            cnt_q     <= '0;
            settle_q  <= '0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            backoff_q <= 1'b0;
            oor_q     <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            load_q    <= 1'b0;
            move_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            cnt_q     <= cnt_d;
            settle_q  <= settle_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            backoff_q <= backoff_d;
            oor_q     <= DELAY_LINE_OUT_OF_RANGE;
            ready_q   <= (state_d == ST_IDLE);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_FIN);
            load_q    <= (state_d == ST_LOAD);
            move_q    <= (state_d == ST_MOVE);
        end
    end

    assign REQ_READY            = ready_q;
    assign BUSY                 = busy_q;
    assign DONE                 = done_q;
    assign ERR                  = err_q;
    assign TAP_POS              = tap_q;
    assign DELAY_LINE_LOAD      = load_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign DELAY_LINE_DIRECTION = dir_q;

endmodule

// File: tb/tb_ca_tx_delay_ctrl.sv
// Bench for ca_tx_delay_ctrl: directed scenarios plus random requests against a transaction-level model.
module tb_ca_tx_delay_ctrl;
    import ddr_phy_pkg::*;

    localparam int unsigned TAP_W    = 8;
    localparam int unsigned TAP_INIT = 1;
    localparam int unsigned TAP_MAX  = 255;
    localparam int unsigned S        = 4;

    logic             FAB_CLK = 1'b0;
    logic             ARST_N;
    logic             REQ_VALID = 1'b0;
    logic             REQ_READY;
    logic [1:0]       REQ_OP = 2'b11;
    logic [TAP_W-1:0] REQ_COUNT = '0;
    logic             DONE, ERR, BUSY;
    logic             ERR_CLR = 1'b0;
    logic [TAP_W-1:0] TAP_POS;
    logic             DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION;
    logic             DELAY_LINE_OUT_OF_RANGE = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int tap_model = TAP_INIT;
    int err_model = 0;

    ca_tx_delay_ctrl #(
        .TAP_W(TAP_W), .TAP_INIT(TAP_INIT), .TAP_MAX(TAP_MAX), .SETTLE_CYCLES(S)
    ) dut (
        .FAB_CLK(FAB_CLK), .ARST_N(ARST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP), .REQ_COUNT(REQ_COUNT),
        .DONE(DONE), .ERR(ERR), .ERR_CLR(ERR_CLR), .BUSY(BUSY), .TAP_POS(TAP_POS),
        .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
        .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One request: model the outcome from the stepping rules, then drive and observe the DUT
    task automatic run_req(input logic [1:0] op, input int cnt, input int oor_at, input bit clr_during);
        int  pos, exp_lat, exp_moves, exp_loads, exp_err;
        bit  backoff;
        bit  inc;
        int  guard, cyc, done_cyc, moves, loads, overlap, dir_bad, tap_at_done, err_at_done;
        logic exp_dir;

        pos = tap_model; exp_moves = 0; exp_loads = 0; exp_err = 0; backoff = 0;
        inc = (op == OP_INC);
        if (op == OP_LOAD) begin
            exp_lat = 2; exp_loads = 1; pos = TAP_INIT;
        end else if (op == OP_NOP || cnt == 0) begin
            exp_lat = 1;
        end else begin
            exp_lat = 1;
            for (int i = 0; i < cnt; i++) begin
                if (inc ? (pos == TAP_MAX) : (pos == 0)) begin exp_err = 1; break; end
                exp_moves++; exp_lat += 1 + S;
                if (exp_moves == oor_at) begin
                    exp_err = 1;
`ifdef CA_TX_DELAY_OOR_BACKOFF_EN
                    exp_moves++; exp_lat += 2 + S; backoff = 1;
`endif
                    break;
                end
                pos += inc ? 1 : -1;
            end
            exp_lat += 1;
        end

        guard = 0;
        while (!REQ_READY && guard < 50) begin @(negedge FAB_CLK); guard++; end
        check_eq("ready_before_req", 32'(REQ_READY), 32'd1);
        REQ_VALID = 1'b1; REQ_OP = op; REQ_COUNT = TAP_W'(cnt); ERR_CLR = clr_during;
        @(posedge FAB_CLK);

        cyc = 0; done_cyc = -1; moves = 0; loads = 0; overlap = 0; dir_bad = 0;
        tap_at_done = -1; err_at_done = -1;
        while (cyc < exp_lat + 20 && done_cyc < 0) begin
            @(negedge FAB_CLK);
            cyc++;
            REQ_VALID = 1'b0;
            if (cyc == 1) begin
                check_eq("busy_after_accept", 32'(BUSY), 32'd1);
                check_eq("ready_after_accept", 32'(REQ_READY), 32'd0);
            end
            if (DELAY_LINE_MOVE) begin
                moves++;
                exp_dir = (backoff && moves == exp_moves) ? ~inc : inc;
                if (DELAY_LINE_DIRECTION !== exp_dir) dir_bad++;
                if (moves == oor_at) DELAY_LINE_OUT_OF_RANGE = 1'b1;
            end
            if (DELAY_LINE_LOAD) loads++;
            if (DELAY_LINE_MOVE && DELAY_LINE_LOAD) overlap++;
            if (DONE) begin
                done_cyc = cyc; tap_at_done = 32'(TAP_POS); err_at_done = 32'(ERR);
            end
        end
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
        ERR_CLR = 1'b0;

        err_model = clr_during ? exp_err : (err_model | exp_err);
        tap_model = pos;
        check_eq("done_latency", 32'(done_cyc), 32'(exp_lat));
        check_eq("move_pulses", 32'(moves), 32'(exp_moves));
        check_eq("load_pulses", 32'(loads), 32'(exp_loads));
        check_eq("move_load_overlap", 32'(overlap), 32'd0);
        check_eq("direction_at_move", 32'(dir_bad), 32'd0);
        check_eq("tap_at_done", 32'(tap_at_done), 32'(tap_model));
        check_eq("err_at_done", 32'(err_at_done), 32'(err_model));
        @(negedge FAB_CLK);
        check_eq("done_single_cycle", 32'(DONE), 32'd0);
        check_eq("busy_after_done", 32'(BUSY), 32'd0);
        check_eq("err_hold", 32'(ERR), 32'(err_model));
    endtask

    task automatic clear_err();
        @(negedge FAB_CLK);
        ERR_CLR = 1'b1;
        @(negedge FAB_CLK);
        ERR_CLR = 1'b0;
        err_model = 0;
        check_eq("err_clr", 32'(ERR), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(REQ_READY), 32'd0);
        check_eq({tag, "_done"}, 32'(DONE), 32'd0);
        check_eq({tag, "_err"}, 32'(ERR), 32'd0);
        check_eq({tag, "_busy"}, 32'(BUSY), 32'd0);
        check_eq({tag, "_tap"}, 32'(TAP_POS), 32'(TAP_INIT));
        check_eq({tag, "_load"}, 32'(DELAY_LINE_LOAD), 32'd0);
        check_eq({tag, "_move"}, 32'(DELAY_LINE_MOVE), 32'd0);
    endtask

    initial begin
        int op_r, cnt_r, oor_r;

        ARST_N = 1'b1;
        #1 ARST_N = 1'b0;
        #1 check_reset_outputs("reset");
        check_eq("reset_dir", 32'(DELAY_LINE_DIRECTION), 32'd0);
        repeat (2) @(negedge FAB_CLK);
        ARST_N = 1'b1;
        repeat (2) @(negedge FAB_CLK);
        check_eq("ready_after_reset", 32'(REQ_READY), 32'd1);

        run_req(OP_LOAD, 0, 0, 0);
        run_req(OP_INC, 3, 0, 0);
        run_req(OP_DEC, 2, 0, 0);
        run_req(OP_DEC, 5, 0, 0);
        clear_err();
        run_req(OP_NOP, 7, 0, 0);
        run_req(OP_INC, 0, 0, 0);
        run_req(OP_INC, 4, 2, 0);
        clear_err();
        run_req(OP_LOAD, 0, 0, 0);
        run_req(OP_DEC, 1, 0, 0);
        run_req(OP_DEC, 1, 0, 1);
        clear_err();
        run_req(OP_INC, 255, 0, 0);
        run_req(OP_INC, 1, 0, 0);
        clear_err();
        run_req(OP_LOAD, 0, 0, 0);

        for (int t = 0; t < 30; t++) begin
            op_r  = int'($urandom_range(0, 3));
            cnt_r = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 60)) : int'($urandom_range(0, 6));
            oor_r = 0;
            if ((op_r == 1 || op_r == 2) && cnt_r > 0 && $urandom_range(0, 3) == 0)
                oor_r = int'($urandom_range(1, cnt_r));
            run_req(2'(op_r), cnt_r, oor_r, 0);
            if ($urandom_range(0, 3) == 0) clear_err();
        end

        // Reset asserted during the second settle window of a three-step increment
        run_req(OP_LOAD, 0, 0, 0);
        @(negedge FAB_CLK);
        REQ_VALID = 1'b1; REQ_OP = OP_INC; REQ_COUNT = TAP_W'(3);
        @(posedge FAB_CLK);
        for (int c = 1; c <= 8; c++) begin
            @(negedge FAB_CLK);
            REQ_VALID = 1'b0;
        end
        #2 ARST_N = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(negedge FAB_CLK);
        ARST_N = 1'b1;
        tap_model = TAP_INIT;
        err_model = 0;
        repeat (2) @(negedge FAB_CLK);
        check_eq("ready_after_mid_reset", 32'(REQ_READY), 32'd1);
        run_req(OP_NOP, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
